// File: rtl/msx_slot_pkg.sv
// msx_slot_pkg: shared constants and types for the MSX primary/sub-slot selector
package msx_slot_pkg;
  localparam logic [7:0]  PORT_PPI_A    = 8'hA8;
  localparam logic [7:0]  PORT_MAP_BASE = 8'hFC;
  localparam logic [15:0] SUBSLOT_ADDR  = 16'hFFFF;
  typedef logic [1:0] page_t;
  typedef struct packed {
    logic [1:0] prim;
    logic [1:0] sub;
  } slot_id_t;
  function automatic logic [1:0] page_field(input logic [7:0] r, input page_t p);
    return r[{p, 1'b0} +: 2];
  endfunction
endpackage

// File: rtl/msx_slot_expander_io_wr_strobe.sv
// io_wr_strobe: one-clock pulse on the first clk a write qualifier is seen true
module io_wr_strobe (
  input  logic clk,
  input  logic reset,
  input  logic qual_i,
  output logic pulse_o
);
  logic qual_q;
  // Held high through reset so a cycle already in flight cannot fire afterwards
  always_ff @(posedge clk) begin
    if (reset) qual_q <= 1'b1;
    else       qual_q <= qual_i;
  end
  assign pulse_o = qual_i & ~qual_q & ~reset;
endmodule

// File: rtl/msx_slot_expander.sv
// msx_slot_expander: PPI A8h slot register, FFFFh sub-slot registers, one-hot slot decode; MSX_MEMMAP_EN adds FCh-FFh RAM mapper
module msx_slot_expander
  import msx_slot_pkg::*;
#(
  parameter logic [3:0] EXPANDED    = 4'b1000,
  parameter int         MAPPER_BITS = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            addr,
  input  logic [7:0]             d_from_cpu,
  input  logic                   mreq_n,
  input  logic                   iorq_n,
  input  logic                   rd_n,
  input  logic                   wr_n,
  input  logic                   m1_n,
  input  logic                   rfrsh_n,
  output logic [15:0]            slot_sel_n,
  output logic [1:0]             prim_slot,
  output logic [1:0]             sub_slot,
  output logic [7:0]             ppi_a,
  output logic [7:0]             d_out,
  output logic                   d_oe,
  output logic [MAPPER_BITS-1:0] ram_seg
);
  logic [7:0] ppi_q, ppi_d;
  logic [3:0][7:0] sub_q, sub_d;
  logic io_cyc, mem_cyc, ffff_hit, io_stb, mem_stb;
  logic sub_rd, ppi_rd, map_rd;
  logic [7:0] map_rdata;
  logic [1:0] p3;
  page_t page;
  slot_id_t sid;
  assign page     = addr[15:14];
  assign p3       = ppi_q[7:6];
  assign io_cyc   = ~iorq_n & m1_n;
  assign mem_cyc  = ~mreq_n & rfrsh_n;
  assign ffff_hit = (addr == SUBSLOT_ADDR) & EXPANDED[p3];
  io_wr_strobe u_io_stb (
    .clk(clk), .reset(reset), .qual_i(io_cyc & ~wr_n), .pulse_o(io_stb)
  );
  io_wr_strobe u_mem_stb (
    .clk(clk), .reset(reset), .qual_i(mem_cyc & ~wr_n & ffff_hit), .pulse_o(mem_stb)
  );
  always_comb begin
    sid.prim = page_field(ppi_q, page);
    sid.sub  = EXPANDED[sid.prim] ? page_field(sub_q[sid.prim], page) : 2'd0;
  end
  assign prim_slot  = sid.prim;
  assign sub_slot   = sid.sub;
  assign ppi_a      = ppi_q;
  // Accesses to the sub-slot register itself never reach a slot
  assign slot_sel_n = (!mem_cyc || ffff_hit) ? 16'hFFFF : ~(16'd1 << sid);
  always_comb begin
    ppi_d = (io_stb && addr[7:0] == PORT_PPI_A) ? d_from_cpu : ppi_q;
    sub_d = sub_q;
    if (mem_stb) sub_d[p3] = d_from_cpu;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ppi_q <= 8'h00;
      sub_q <= '0;
    end else begin
      ppi_q <= ppi_d;
      sub_q <= sub_d;
    end
  end
`ifdef MSX_MEMMAP_EN
  logic [3:0][MAPPER_BITS-1:0] map_q, map_d;
  logic map_hit;
  assign map_hit = addr[7:2] == PORT_MAP_BASE[7:2];
  always_comb begin
    map_d = map_q;
    if (io_stb && map_hit) map_d[addr[1:0]] = d_from_cpu[MAPPER_BITS-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) map_q <= {MAPPER_BITS'(0), MAPPER_BITS'(1), MAPPER_BITS'(2), MAPPER_BITS'(3)};
    else       map_q <= map_d;
  end
  assign map_rd    = io_cyc & ~rd_n & map_hit;
  assign map_rdata = (8'hFF << MAPPER_BITS) | 8'(map_q[addr[1:0]]);
  assign ram_seg   = map_q[page];
`else
  assign map_rd    = 1'b0;
  assign map_rdata = 8'hFF;
  assign ram_seg   = '0;
`endif
  assign sub_rd = mem_cyc & ~rd_n & ffff_hit;
  assign ppi_rd = io_cyc & ~rd_n & (addr[7:0] == PORT_PPI_A);
  assign d_oe   = sub_rd | ppi_rd | map_rd;
  assign d_out  = sub_rd ? ~sub_q[p3] : ppi_rd ? ppi_q : map_rd ? map_rdata : 8'hFF;
endmodule

// File: tb/tb_msx_slot_expander.sv
// tb_msx_slot_expander: directed bus cycles with a queued-expectation scoreboard
module tb_msx_slot_expander;
  localparam int MB = 3;
  logic clk = 1'b0, reset = 1'b1;
  logic [15:0] addr;
  logic [7:0] d_from_cpu;
  logic mreq_n, iorq_n, rd_n, wr_n, m1_n, rfrsh_n;
  logic [15:0] slot_sel_n;
  logic [1:0] prim_slot, sub_slot;
  logic [7:0] ppi_a, d_out;
  logic d_oe;
  logic [MB-1:0] ram_seg;
  int total = 0, bad = 0;
  typedef struct {
    string nm;
    logic [15:0] sel;
    logic [1:0] prim, sub;
    logic oe;
    logic [7:0] dout, ppi;
    logic [MB-1:0] rs;
  } exp_t;
  exp_t q[$];
`ifdef MSX_MEMMAP_EN
  logic [MB-1:0] map_m [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
`else
  logic [MB-1:0] map_m [4] = '{3'd0, 3'd0, 3'd0, 3'd0};
`endif

  msx_slot_expander #(.EXPANDED(4'b1000), .MAPPER_BITS(MB)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_from_cpu(d_from_cpu),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .rfrsh_n(rfrsh_n),
    .slot_sel_n(slot_sel_n), .prim_slot(prim_slot), .sub_slot(sub_slot), .ppi_a(ppi_a),
    .d_out(d_out), .d_oe(d_oe), .ram_seg(ram_seg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : monitor
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (slot_sel_n !== e.sel || prim_slot !== e.prim || sub_slot !== e.sub || d_oe !== e.oe ||
          d_out !== e.dout || ppi_a !== e.ppi || ram_seg !== e.rs) begin
        bad++;
        $display("FAIL %s: got sel=%h prim=%0d sub=%0d oe=%b dout=%h ppi=%h seg=%0d want sel=%h prim=%0d sub=%0d oe=%b dout=%h ppi=%h seg=%0d",
                 e.nm, slot_sel_n, prim_slot, sub_slot, d_oe, d_out, ppi_a, ram_seg,
                 e.sel, e.prim, e.sub, e.oe, e.dout, e.ppi, e.rs);
      end
    end
  end

  task automatic idle();
    mreq_n = 1; iorq_n = 1; rd_n = 1; wr_n = 1; m1_n = 1; rfrsh_n = 1; d_from_cpu = 8'h00;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic chk(input string nm, input logic [15:0] sel, input logic [1:0] pr, input logic [1:0] sb,
                     input logic oe, input logic [7:0] dout, input logic [7:0] ppi);
    exp_t e;
    e = '{nm, sel, pr, sb, oe, dout, ppi, map_m[addr[15:14]]};
    q.push_back(e);
    tick();
  endtask
  task automatic io_wr(input logic [7:0] a, input logic [7:0] d);
    idle(); iorq_n = 0; wr_n = 0; addr = {8'h00, a}; d_from_cpu = d;
    tick(); idle(); tick();
  endtask
  task automatic mrd(input logic [15:0] a);
    idle(); mreq_n = 0; rd_n = 0; addr = a;
  endtask
  task automatic ird(input logic [7:0] a);
    idle(); iorq_n = 0; rd_n = 0; addr = {8'h00, a};
  endtask

  initial begin
    idle(); addr = 16'h0000;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    mrd(16'h0000); chk("rst_rd0",    16'hFFFE, 0, 0, 0, 8'hFF, 8'h00);
    ird(8'hA8);    chk("rst_ppi",    16'hFFFF, 0, 0, 1, 8'h00, 8'h00);
    io_wr(8'hA8, 8'hC0);
    mrd(16'hC000); chk("c000_p3",    16'hEFFF, 3, 0, 0, 8'hFF, 8'hC0);
    mrd(16'h8000); chk("8000_p0",    16'hFFFE, 0, 0, 0, 8'hFF, 8'hC0);
    ird(8'hA8);    chk("ppi_c0",     16'hFFFF, 0, 0, 1, 8'hC0, 8'hC0);
    idle(); mreq_n = 0; wr_n = 0; addr = 16'hFFFF; d_from_cpu = 8'h40;
    chk("ffff_absorb", 16'hFFFF, 3, 0, 0, 8'hFF, 8'hC0);
    idle(); tick();
    mrd(16'hFFFF); chk("ffff_rd",    16'hFFFF, 3, 1, 1, 8'hBF, 8'hC0);
    mrd(16'hC000); chk("c000_sub1",  16'hDFFF, 3, 1, 0, 8'hFF, 8'hC0);
    mrd(16'h0000); chk("0000_p0",    16'hFFFE, 0, 0, 0, 8'hFF, 8'hC0);
    idle(); iorq_n = 0; wr_n = 0; addr = 16'h00A8; d_from_cpu = 8'h11;
    tick(); d_from_cpu = 8'h22;
    repeat (4) tick();
    idle(); tick();
    ird(8'hA8);    chk("long_wr",    16'hFFFF, 1, 0, 1, 8'h11, 8'h11);
    mrd(16'h0000); chk("0000_p1",    16'hFFEF, 1, 0, 0, 8'hFF, 8'h11);
    mrd(16'hC000); chk("c000_p0",    16'hFFFE, 0, 0, 0, 8'hFF, 8'h11);
    idle(); mreq_n = 0; rfrsh_n = 0; addr = 16'hC000;
    chk("rfsh",      16'hFFFF, 0, 0, 0, 8'hFF, 8'h11);
    idle(); iorq_n = 0; wr_n = 0; addr = 16'h00A8; d_from_cpu = 8'h77; reset = 1;
    tick(); reset = 0; tick(); idle(); tick();
    ird(8'hA8);    chk("rst_mid",    16'hFFFF, 0, 0, 1, 8'h00, 8'h00);
    idle(); mreq_n = 0; wr_n = 0; addr = 16'hFFFF; d_from_cpu = 8'h55;
    chk("ffff_noexp", 16'hFFFE, 0, 0, 0, 8'hFF, 8'h00);
    idle(); tick();
    io_wr(8'hA8, 8'hC0);
    mrd(16'hC000); chk("sub_cleared", 16'hEFFF, 3, 0, 0, 8'hFF, 8'hC0);
    idle(); iorq_n = 0; m1_n = 0; wr_n = 0; addr = 16'h00A8; d_from_cpu = 8'h33;
    tick(); idle(); tick();
    ird(8'hA8);    chk("m1_ignored", 16'hFFFF, 0, 0, 1, 8'hC0, 8'hC0);
`ifdef MSX_MEMMAP_EN
    ird(8'hFD);    chk("fd_pre",     16'hFFFF, 0, 0, 1, 8'hFA, 8'hC0);
    io_wr(8'hFD, 8'h05); map_m[1] = 3'd5;
    mrd(16'h4000); chk("4000_seg",   16'hFFFE, 0, 0, 0, 8'hFF, 8'hC0);
    ird(8'hFD);    chk("fd_post",    16'hFFFF, 0, 0, 1, 8'hFD, 8'hC0);
`else
    ird(8'hFD);    chk("fd_pre",     16'hFFFF, 0, 0, 0, 8'hFF, 8'hC0);
    io_wr(8'hFD, 8'h05);
    mrd(16'h4000); chk("4000_seg",   16'hFFFE, 0, 0, 0, 8'hFF, 8'hC0);
    ird(8'hFD);    chk("fd_post",    16'hFFFF, 0, 0, 0, 8'hFF, 8'hC0);
`endif
    idle();
    repeat (2) tick();
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
